// File: rtl/i2c_poller.sv
`default_nettype none
// ============================================================================
// i2c_poller : autonomous register poller sitting upstream of the I2C master
// Rev 1.0
// ============================================================================
module i2c_poller #(
  parameter logic [6:0] SLVADDR = 7'h48,
  parameter logic [7:0] REGPTR  = 8'h00,
  parameter int         NBYTES  = 2,
  parameter int         PERIOD  = 1000000,
  parameter int         TIMEOUT = 65535
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        enable,
  input  logic        trigger,
  input  logic [63:0] mstatus,
  output logic        wrcmd,
  output logic [63:0] command,
  output logic [55:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic [1:0]  lasterr,
  output logic [7:0]  errcnt,
  output logic [15:0] okcnt
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
  localparam logic [PW-1:0] C_PLAST = PW'(PERIOD - 1);
  localparam logic [TW-1:0] C_TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] C_TMAX  = TW'(TIMEOUT);

  // Write address, register pointer, repeated-start read address, one read opcode per byte, stop.
  function automatic logic [63:0] build_cmd();
    logic [63:0] w;
    w = {2'b11, SLVADDR, 1'b0, 2'b11, REGPTR, 2'b01, 2'b11, SLVADDR, 1'b1, 32'd0};
    for (int i = 0; i < NBYTES; i++) w[31-2*i -: 2] = 2'b10;
    return w;
  endfunction

  localparam logic [63:0] C_CMD = build_cmd();

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptmr;
  logic            r_pend;
  logic [TW-1:0]   r_tcnt;
  logic            w_wrap;
  logic            w_start;
  logic            w_tout;
  logic            w_fail;
  logic            w_good;
  logic            w_unused;

  assign w_wrap   = enable && (r_ptmr == C_PLAST);
  assign w_fail   = w_tout || ((r_state == S_DONE) && mstatus[62]);
  assign w_good   = (r_state == S_DONE) && !mstatus[62];
  assign wrcmd    = (r_state == S_ISSUE);
  assign busy     = (r_state != S_IDLE);
  assign w_unused = ^mstatus[61:NBYTES*8];

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_tout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_next  = S_ISSUE;
          w_start = 1'b1;
        end
      end
      S_ISSUE: w_next = S_ARM;
      S_ARM:   w_next = S_WAIT;
      S_WAIT: begin
        if (!mstatus[63]) begin
          w_next = S_DONE;
        end else if (r_tcnt == C_TLAST) begin
          w_next = S_IDLE;
          w_tout = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_ptmr  <= '0;
      r_pend  <= 1'b0;
      r_tcnt  <= '0;
      command <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      lasterr <= 2'b00;
      errcnt  <= 8'd0;
      okcnt   <= 16'd0;
    end else begin
      r_ptmr <= enable ? (w_wrap ? '0 : r_ptmr + 1'b1) : '0;
      // Requests arriving while one is already pending or a poll is in flight collapse into one.
      if (w_start)                 r_pend <= 1'b0;
      else if (trigger || w_wrap)  r_pend <= 1'b1;
      if (w_start) command <= C_CMD;
      if (r_state == S_ARM)                          r_tcnt <= '0;
      else if (r_state == S_WAIT && r_tcnt != C_TMAX) r_tcnt <= r_tcnt + 1'b1;
      rvalid <= 1'b0;
      if (w_fail) begin
        lasterr <= w_tout ? 2'b10 : 2'b01;
        if (errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
      end
      if (w_good) begin
        rdata   <= 56'(mstatus[NBYTES*8-1:0]);
        rvalid  <= 1'b1;
        lasterr <= 2'b00;
        okcnt   <= okcnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
